// File: rtl/branch_resolve_ctrl_pkg.sv
// Pipeline definitions shared by the ID-stage branch resolution logic.
package branch_resolve_ctrl_pkg;

  // Branch type encodings carried on br_type; 6 and 7 are unassigned.
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLEZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  // Comparator mode: D1 against zero, or D1-D2.
  localparam logic CMP_ZERO = 1'b0;
  localparam logic CMP_SUB  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_cond.sv
// Branch condition decode: maps type and comparator flags to taken/uses_rt/legal.
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       z,
  input  logic       l,
  output logic       taken,
  output logic       uses_rt,
  output logic       legal
);

  // Per-type condition; unassigned types are flagged illegal and never taken.
  always_comb begin
    taken   = 1'b0;
    uses_rt = CMP_ZERO;
    legal   = 1'b1;
    case (br_type)
      BR_BEQ: begin
        taken   = z;
        uses_rt = CMP_SUB;
      end
      BR_BNE: begin
        taken   = ~z;
        uses_rt = CMP_SUB;
      end
      BR_BLEZ: taken = l | z;
      BR_BGTZ: taken = ~l & ~z;
      BR_BLTZ: taken = l;
      BR_BGEZ: taken = ~l;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: operand-wait stall, zero-latency resolve,
// one-shot redirect/flush, saturating statistics and sticky wait timeout.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             pipe_hold,
  input  logic             cmp_zero,
  input  logic             cmp_lzero,
  output logic             cmp_op,
  output logic             stall_id,
  output logic             redirect,
  output logic             flush_if,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic             wait_err,
  output logic             illegal_type
);

  localparam int unsigned      WCNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);

  br_state_e         state;
  br_state_e         state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_nxt;
  logic              taken;
  logic              uses_rt;
  logic              legal;
  logic              taken_q;
  logic              ops_ready;
  logic              resolve;

  branch_cond_eval u_cond (
    .br_type (br_type),
    .z       (cmp_zero),
    .l       (cmp_lzero),
    .taken   (taken),
    .uses_rt (uses_rt),
    .legal   (legal)
  );

  // Operands are complete once rs (and rt when the compare needs it) forward.
  always_comb begin
    ops_ready = rs_ready & (rt_ready | ~uses_rt);
  end

  // State and operand-wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state; an illegal type leaves state and wait count untouched.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (br_valid && legal) begin
          if (!ops_ready) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WCNT_W'(1);
          end else if (pipe_hold) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (!br_valid) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end else if (legal) begin
          if (ops_ready) begin
            state_nxt    = pipe_hold ? ST_DONE : ST_IDLE;
            wait_cnt_nxt = '0;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + WCNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!pipe_hold || !br_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs, all forced low while reset is asserted.
  always_comb begin
    cmp_op       = 1'b0;
    stall_id     = 1'b0;
    redirect     = 1'b0;
    illegal_type = 1'b0;
    resolve      = 1'b0;
    if (!reset) begin
      cmp_op       = uses_rt;
      illegal_type = br_valid & ~legal;
      case (state)
        ST_IDLE, ST_WAIT: begin
          stall_id = br_valid & legal & ~ops_ready;
          resolve  = br_valid & legal & ops_ready;
          redirect = resolve & taken;
        end
        ST_DONE:  redirect = taken_q;
        default:  redirect = 1'b0;
      endcase
    end
    flush_if = redirect;
  end

  // Statistics, held outcome for DONE, and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count    <= '0;
      taken_count <= '0;
      taken_q     <= 1'b0;
      wait_err    <= 1'b0;
    end else begin
      if (resolve) begin
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        if (taken && (taken_count != '1)) taken_count <= taken_count + CNT_W'(1);
        if (pipe_hold) taken_q <= taken;
      end
      // Flag on the cycle the count reaches the limit so it is visible
      // after exactly MAX_WAIT stalled cycles.
      if (wait_cnt_nxt == WAIT_LIMIT) wait_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl with a per-cycle expectation queue.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  typedef struct packed {
    logic        stall;
    logic        redirect;
    logic        flush;
    logic        illegal;
    logic        cmp_op;
    logic        wait_err;
    logic [31:0] brc;
    logic [31:0] tkc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_type;
  logic        rs_ready, rt_ready, pipe_hold, cmp_zero, cmp_lzero;
  logic        cmp_op, stall_id, redirect, flush_if, wait_err, illegal_type;
  logic [31:0] br_count, taken_count;
  logic        s_cmp_op, s_stall_id, s_redirect, s_flush_if, s_wait_err, s_illegal_type;
  logic [3:0]  s_br_count, s_taken_count;

  obs_t        sb[$];
  logic [31:0] m_br, m_tk;
  logic        m_err;
  logic [3:0]  s_br, s_tk;
  int          n_chk, n_pass;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.CNT_W(32), .MAX_WAIT(4)) u_dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .pipe_hold(pipe_hold),
    .cmp_zero(cmp_zero), .cmp_lzero(cmp_lzero), .cmp_op(cmp_op),
    .stall_id(stall_id), .redirect(redirect), .flush_if(flush_if),
    .br_count(br_count), .taken_count(taken_count), .wait_err(wait_err),
    .illegal_type(illegal_type)
  );

  branch_resolve_ctrl #(.CNT_W(4), .MAX_WAIT(4)) u_sat (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .pipe_hold(pipe_hold),
    .cmp_zero(cmp_zero), .cmp_lzero(cmp_lzero), .cmp_op(s_cmp_op),
    .stall_id(s_stall_id), .redirect(s_redirect), .flush_if(s_flush_if),
    .br_count(s_br_count), .taken_count(s_taken_count), .wait_err(s_wait_err),
    .illegal_type(s_illegal_type)
  );

  function automatic obs_t observe();
    return '{stall_id, redirect, flush_if, illegal_type, cmp_op, wait_err, br_count, taken_count};
  endfunction

  // Drive one cycle of inputs and queue the outputs the spec requires for it.
  task automatic apply(input logic v, input logic [2:0] t, input logic rs, input logic rt,
                       input logic hold, input logic z, input logic l,
                       input logic e_st, input logic e_rd, input logic e_il, input logic e_cm);
    br_valid = v; br_type = t; rs_ready = rs; rt_ready = rt;
    pipe_hold = hold; cmp_zero = z; cmp_lzero = l;
    sb.push_back('{e_st, e_rd, e_rd, e_il, e_cm, m_err, m_br, m_tk});
  endtask

  task automatic idle();
    apply(1'b0, BR_BLTZ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int c = 0; c < 2; c++) begin
      reset = 1'b1;
      apply(1'b1, BR_BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL reset[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_beq_taken();
    obs_t got, exp;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) apply(1'b1, BR_BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      else idle();
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL beq_taken[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 0) begin m_br = m_br + 1; m_tk = m_tk + 1; end
    end
  endtask

  task automatic test_bne_wait();
    obs_t got, exp;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0, 1:    apply(1'b1, BR_BNE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        2:       apply(1'b1, BR_BNE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        default: idle();
      endcase
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL bne_wait[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 2) m_br = m_br + 1;
    end
  endtask

  task automatic test_bgtz_hold();
    obs_t got, exp;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       apply(1'b1, BR_BGTZ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        1, 2:    apply(1'b1, BR_BGTZ, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        3:       apply(1'b1, BR_BGTZ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        default: idle();
      endcase
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL bgtz_hold[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 0) begin m_br = m_br + 1; m_tk = m_tk + 1; end
    end
  endtask

  task automatic test_wait_timeout();
    obs_t got, exp;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0, 1, 2, 3: apply(1'b1, BR_BLEZ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        4:          apply(1'b1, BR_BLEZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        default:    idle();
      endcase
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL wait_timeout[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 3) m_err = 1'b1;
      if (c == 4) begin m_br = m_br + 1; m_tk = m_tk + 1; end
    end
  endtask

  task automatic test_illegal();
    obs_t got, exp;
    logic [2:0] t7, t6;
    t7 = 3'd7; t6 = 3'd6;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       apply(1'b1, t7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        1:       apply(1'b1, t6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        2:       apply(1'b1, BR_BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        4:       apply(1'b1, BR_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        5:       apply(1'b1, t7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        6:       apply(1'b1, BR_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        default: idle();
      endcase
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL illegal[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 2) begin m_br = m_br + 1; m_tk = m_tk + 1; end
      if (c == 6) m_br = m_br + 1;
    end
  endtask

  task automatic test_reset_in_wait();
    obs_t got, exp;
    for (int c = 0; c < 5; c++) begin
      reset = (c == 2);
      case (c)
        0, 1:    apply(1'b1, BR_BNE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        2:       apply(1'b1, BR_BNE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        3:       apply(1'b1, BR_BNE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        default: idle();
      endcase
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL reset_in_wait[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 2) begin m_br = '0; m_tk = '0; m_err = 1'b0; end
      if (c == 3) begin m_br = m_br + 1; m_tk = m_tk + 1; end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       apply(1'b1, BR_BEQ,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        1:       apply(1'b1, BR_BNE,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        2:       apply(1'b1, BR_BLTZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        3:       apply(1'b1, BR_BEQ,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        5:       apply(1'b1, BR_BGEZ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        6:       apply(1'b1, BR_BGEZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        default: idle();
      endcase
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL back_to_back[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (c == 0 || c == 1) begin m_br = m_br + 1; m_tk = m_tk + 1; end
      if (c == 2 || c == 5) m_br = m_br + 1;
    end
  endtask

  task automatic test_saturation();
    obs_t got, exp;
    for (int c = 0; c < 20; c++) begin
      reset = (c == 0);
      if (c == 0) apply(1'b1, BR_BGEZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (c < 19) apply(1'b1, BR_BGEZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else idle();
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL saturation[%0d]: got %p expected %p", c, got, exp);
      else n_pass++;
      if (c > 0) begin
        n_chk++;
        if ({s_br_count, s_taken_count} !== {s_br, s_tk})
          $display("FAIL sat_counts[%0d]: got br=%h taken=%h expected br=%h taken=%h",
                   c, s_br_count, s_taken_count, s_br, s_tk);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        m_br = '0; m_tk = '0; m_err = 1'b0; s_br = '0; s_tk = '0;
      end else if (c < 19) begin
        m_br = m_br + 1; m_tk = m_tk + 1;
        if (s_br != 4'hF) s_br = s_br + 4'd1;
        if (s_tk != 4'hF) s_tk = s_tk + 4'd1;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    m_br = '0; m_tk = '0; m_err = 1'b0; s_br = '0; s_tk = '0;
    reset = 1'b1;
    br_valid = 1'b0; br_type = BR_BLTZ; rs_ready = 1'b0; rt_ready = 1'b0;
    pipe_hold = 1'b0; cmp_zero = 1'b0; cmp_lzero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_beq_taken();
    test_bne_wait();
    test_bgtz_hold();
    test_wait_timeout();
    test_illegal();
    test_reset_in_wait();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
